// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Baud divisors are derived from the system clock at elaboration time.
`timescale 1ns/1ps
package uart_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CAPTURE  = 2'd1,
      ST_WAIT_LOW = 2'd2
   } rx_state_t;

   typedef struct packed {
      logic       irq_en;
      logic       ohel;
      logic       pen;
      logic       eight;
      logic [3:0] baud_sel;
   } rx_cfg_t;

   typedef struct packed {
      logic       ovf;
      logic       ferr;
      logic       perr;
      logic [7:0] data;
   } rx_entry_t;

   localparam logic [7:0] CFG_RESET = 8'h18;

   localparam logic [3:0] BAUD_300    = 4'd0;
   localparam logic [3:0] BAUD_1200   = 4'd1;
   localparam logic [3:0] BAUD_2400   = 4'd2;
   localparam logic [3:0] BAUD_4800   = 4'd3;
   localparam logic [3:0] BAUD_9600   = 4'd4;
   localparam logic [3:0] BAUD_19200  = 4'd5;
   localparam logic [3:0] BAUD_38400  = 4'd6;
   localparam logic [3:0] BAUD_57600  = 4'd7;
   localparam logic [3:0] BAUD_115200 = 4'd8;
   localparam logic [3:0] BAUD_230400 = 4'd9;
   localparam logic [3:0] BAUD_460800 = 4'd10;
   localparam logic [3:0] BAUD_921600 = 4'd11;

   localparam int ERR_PERR  = 0;
   localparam int ERR_FERR  = 1;
   localparam int ERR_OVF   = 2;
   localparam int ERR_STALL = 3;

   function automatic longint unsigned baud_rate(input logic [3:0] code);
      longint unsigned rate;
      case (code)
         BAUD_300:    rate = 64'd300;
         BAUD_1200:   rate = 64'd1200;
         BAUD_2400:   rate = 64'd2400;
         BAUD_4800:   rate = 64'd4800;
         BAUD_9600:   rate = 64'd9600;
         BAUD_19200:  rate = 64'd19200;
         BAUD_38400:  rate = 64'd38400;
         BAUD_57600:  rate = 64'd57600;
         BAUD_115200: rate = 64'd115200;
         BAUD_230400: rate = 64'd230400;
         BAUD_460800: rate = 64'd460800;
         BAUD_921600: rate = 64'd921600;
         default:     rate = 64'd115200;
      endcase
      return rate;
   endfunction

   // Rounded divide: (clk + 4*baud) / (8*baud).
   function automatic logic [18:0] baud_k(input logic [3:0] code,
                                          input longint unsigned clk_hz);
      longint unsigned rate;
      rate = baud_rate(code);
      return 19'((clk_hz + rate * 64'd4) / (rate * 64'd8));
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Receive FIFO: first-word fall-through, power-of-two depth.
// Head data reads as zero while empty.
`timescale 1ns/1ps
module rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  rx_entry_t                wdata,
   input  logic                     pop,
   output rx_entry_t                rdata,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rx_entry_t        mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign valid   = (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);
   assign rdata   = valid ? mem[rptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: config register, baud decode, drain FSM,
// receive FIFO, sticky error flags and registered interrupt.
`timescale 1ns/1ps
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int              FIFO_DEPTH = 4,
   parameter longint unsigned CLK_HZ     = 100_000_000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cfg_we,
   input  logic [7:0]                      cfg_wdata,
   output logic [7:0]                      cfg_q,
   output logic [18:0]                     K,
   output logic                            EIGHT,
   output logic                            PEN,
   output logic                            OHEL,
   output logic                            READS0,
   input  logic [7:0]                      UART_RDATA,
   input  logic                            RXRDY,
   input  logic                            PERR,
   input  logic                            FERR,
   input  logic                            OVF,
   input  logic                            rd_req,
   output logic                            rd_valid,
   output logic [7:0]                      rd_data,
   output logic [2:0]                      rd_err,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic [3:0]                      sticky_err,
   input  logic                            clr_err,
   output logic                            irq
);

   rx_cfg_t     cfg;
   logic [18:0] k_tab [16];
   rx_state_t   state;
   rx_state_t   state_nxt;
   logic        capture;
   logic        stall;
   logic        full;
   logic [3:0]  err_set;
   rx_entry_t   wentry;
   rx_entry_t   head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cfg_q <= CFG_RESET;
      else if (cfg_we) cfg_q <= cfg_wdata;
   end

   assign cfg   = rx_cfg_t'(cfg_q);
   assign EIGHT = cfg.eight;
   assign PEN   = cfg.pen;
   assign OHEL  = cfg.ohel;

   for (genvar g = 0; g < 16; g++) begin : g_ktab
      assign k_tab[g] = baud_k(4'(g), CLK_HZ);
   end

   assign K = k_tab[cfg.baud_sel];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Full is judged on the pre-edge count, so a same-cycle pop
   // still costs one stall cycle before the capture.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:     if (RXRDY && !full) state_nxt = ST_CAPTURE;
         ST_CAPTURE:  state_nxt = ST_WAIT_LOW;
         ST_WAIT_LOW: if (!RXRDY) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      capture = 1'b0;
      stall   = 1'b0;
      unique case (1'b1)
         (state == ST_CAPTURE): capture = 1'b1;
         (state == ST_IDLE):    stall   = RXRDY & full;
         default: ;
      endcase
   end

   assign READS0 = capture;

   assign wentry = '{ovf: OVF, ferr: FERR, perr: PERR,
                     data: UART_RDATA};

   rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (capture),
      .wdata (wentry),
      .pop   (rd_req),
      .rdata (head),
      .valid (rd_valid),
      .full  (full),
      .count (fifo_count)
   );

   assign rd_data = head.data;
   assign rd_err  = {head.ovf, head.ferr, head.perr};

   always_comb begin
      err_set            = '0;
      err_set[ERR_STALL] = stall;
      err_set[ERR_OVF]   = capture & OVF;
      err_set[ERR_FERR]  = capture & FERR;
      err_set[ERR_PERR]  = capture & PERR;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       sticky_err <= '0;
      else if (clr_err) sticky_err <= err_set;
      else              sticky_err <= sticky_err | err_set;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) irq <= 1'b0;
      else        irq <= (cfg.irq_en & rd_valid) | (|sticky_err);
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a scoreboard of captured
// characters compared as the host pops them.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
   import uart_rx_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_we;
   logic [7:0]    cfg_wdata;
   logic [7:0]    cfg_q;
   logic [18:0]   K;
   logic          EIGHT, PEN, OHEL, READS0;
   logic [7:0]    UART_RDATA;
   logic          RXRDY, PERR, FERR, OVF;
   logic          rd_req, rd_valid;
   logic [7:0]    rd_data;
   logic [2:0]    rd_err;
   logic [CW-1:0] fifo_count;
   logic [3:0]    sticky_err;
   logic          clr_err, irq;

   int npass  = 0;
   int ntot   = 0;
   int npulse = 0;
   logic [10:0] sb [$];

   int unsigned ktab [16] = '{41667, 10417, 5208, 2604, 1302, 651,
                              326, 217, 109, 54, 27, 14,
                              109, 109, 109, 109};

   uart_rx_ctrl #(
      .FIFO_DEPTH (DEPTH),
      .CLK_HZ     (100_000_000)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_wdata  (cfg_wdata),
      .cfg_q      (cfg_q),
      .K          (K),
      .EIGHT      (EIGHT),
      .PEN        (PEN),
      .OHEL       (OHEL),
      .READS0     (READS0),
      .UART_RDATA (UART_RDATA),
      .RXRDY      (RXRDY),
      .PERR       (PERR),
      .FERR       (FERR),
      .OVF        (OVF),
      .rd_req     (rd_req),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_err     (rd_err),
      .fifo_count (fifo_count),
      .sticky_err (sticky_err),
      .clr_err    (clr_err),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (READS0) npulse <= npulse + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cfg_wr(input logic [7:0] v);
      cfg_we    = 1'b1;
      cfg_wdata = v;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic head_chk(input string tag);
      logic [10:0] e;
      chk({tag, "_valid"}, rd_valid, 1);
      if (sb.size() == 0) begin
         ntot++;
         $error("FAIL %s: observed pop, expected nothing queued", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_data"}, rd_data, e[7:0]);
         chk({tag, "_err"}, rd_err, e[10:8]);
      end
   endtask

   task automatic pop_chk(input string tag);
      head_chk(tag);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic send_char(input logic [7:0] d, input logic [2:0] err);
      logic acked;
      acked = 1'b0;
      UART_RDATA       = d;
      {OVF, FERR, PERR} = err;
      RXRDY            = 1'b1;
      sb.push_back({err, d});
      for (int i = 0; i < 10; i++) begin
         tick();
         if (READS0) begin
            acked = 1'b1;
            break;
         end
      end
      chk("ack", acked, 1);
      RXRDY = 1'b0;
      tick();
      tick();
      {OVF, FERR, PERR} = 3'b000;
   endtask

   initial begin
      logic acked;
      int   p0;
      rst_n      = 1'b0;
      cfg_we     = 1'b0;
      cfg_wdata  = '0;
      UART_RDATA = '0;
      RXRDY      = 1'b0;
      {OVF, FERR, PERR} = 3'b000;
      rd_req     = 1'b0;
      clr_err    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      chk("rst_cfg", cfg_q, 8'h18);
      chk("rst_k", K, 109);
      chk("rst_eight", EIGHT, 1);
      chk("rst_reads0", READS0, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_sticky", sticky_err, 0);
      chk("rst_irq", irq, 0);

      cfg_we    = 1'b1;
      cfg_wdata = 8'h04;
      #1;
      chk("k_before_edge", K, 109);
      tick();
      cfg_we = 1'b0;
      chk("k_1302", K, 1302);
      chk("eight_off", EIGHT, 0);
      cfg_wr(8'h0F);
      chk("k_code15", K, 109);
      for (int c = 0; c < 16; c++) begin
         cfg_wr(8'h10 | 8'(c));
         chk($sformatf("k_tab%0d", c), K, ktab[c]);
      end
      cfg_wr(8'h18);
      chk("cfg_back", cfg_q, 8'h18);

      // 0xA5 with RXRDY held three cycles
      p0 = npulse;
      UART_RDATA = 8'hA5;
      RXRDY      = 1'b1;
      sb.push_back({3'b000, 8'hA5});
      tick();
      chk("a5_ack", READS0, 1);
      chk("a5_notyet", rd_valid, 0);
      tick();
      chk("a5_ack_end", READS0, 0);
      chk("a5_valid", rd_valid, 1);
      chk("a5_count", fifo_count, 1);
      tick();
      chk("a5_no_dbl", READS0, 0);
      RXRDY = 1'b0;
      tick();
      tick();
      chk("a5_pulses", npulse - p0, 1);
      chk("a5_count2", fifo_count, 1);
      pop_chk("a5");
      chk("a5_empty", fifo_count, 0);

      // overflow into a full FIFO
      send_char(8'h11, 3'b000);
      send_char(8'h22, 3'b000);
      send_char(8'h33, 3'b000);
      send_char(8'h44, 3'b000);
      chk("full_count", fifo_count, 4);
      UART_RDATA = 8'h55;
      RXRDY      = 1'b1;
      sb.push_back({3'b000, 8'h55});
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_noack", READS0, 0);
      end
      chk("stall_flag", sticky_err, 4'b1000);
      pop_chk("q11");
      chk("pop_count", fifo_count, 3);
      acked = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (READS0) begin
            acked = 1'b1;
            break;
         end
      end
      chk("late_ack", acked, 1);
      RXRDY = 1'b0;
      tick();
      tick();
      chk("refill_count", fifo_count, 4);
      pop_chk("q22");
      pop_chk("q33");
      pop_chk("q44");
      pop_chk("q55");
      chk("drain_count", fifo_count, 0);
      chk("stall_irq", irq, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_sticky", sticky_err, 0);
      chk("irq_lag", irq, 1);
      tick();
      chk("irq_clear", irq, 0);

      // framing error with irq enabled
      cfg_wr(8'h98);
      chk("irq_en_empty", irq, 0);
      send_char(8'h3C, 3'b010);
      chk("ferr_sticky", sticky_err, 4'b0010);
      chk("ferr_irq", irq, 1);
      clr_err = 1'b1;
      pop_chk("q3c");
      clr_err = 1'b0;
      chk("ferr_clr", sticky_err, 0);
      tick();
      chk("ferr_irq_off", irq, 0);
      cfg_wr(8'h18);

      // capture and pop in the same cycle at count 2
      send_char(8'h61, 3'b000);
      send_char(8'h62, 3'b100);
      chk("cnt2", fifo_count, 2);
      UART_RDATA = 8'h63;
      RXRDY      = 1'b1;
      sb.push_back({3'b000, 8'h63});
      tick();
      chk("same_ack", READS0, 1);
      RXRDY = 1'b0;
      head_chk("q61");
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("same_count", fifo_count, 2);
      tick();
      pop_chk("q62");
      pop_chk("q63");
      chk("ovf_sticky", sticky_err, 4'b0100);

      // reset pulse while in CAPTURE
      cfg_wr(8'h15);
      chk("k_651", K, 651);
      send_char(8'h71, 3'b000);
      UART_RDATA = 8'h72;
      RXRDY      = 1'b1;
      tick();
      chk("pre_rst_ack", READS0, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_reads0_now", READS0, 0);
      chk("rst_flush", rd_valid, 0);
      chk("rst_count_now", fifo_count, 0);
      chk("rst_cfg_now", cfg_q, 8'h18);
      chk("rst_k_now", K, 109);
      chk("rst_sticky_now", sticky_err, 0);
      sb.delete();
      RXRDY = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_irq", irq, 0);
      chk("post_rst_valid", rd_valid, 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
